// File: rtl/control_state_sequencer_pkg.sv
// Control-unit state numbering and IR field positions.
// The state numbers are the output encoder's numbering. That block imports
// this package as well, so any renumbering must happen here and only here.
//
// Contents:
//   cu_state_e           - every legal control state with its fixed encoding
//   IR_* localparams     - bit positions of the ir fields the sequencer decodes
//   OPC_* localparams    - ir[27:25] instruction classes
//   addr_select()        - picks the load/store address state from P/U
//   wb_select()          - picks the writeback state from P/W/U
package control_state_sequencer_pkg;

  typedef enum logic [6:0] {
    S_RESET      = 7'd0,
    S_FETCH1     = 7'd1,
    S_FETCH2     = 7'd2,
    S_FETCH3     = 7'd3,   // instruction fetch, waits for moc
    S_DECODE     = 7'd4,
    S_BL_LINK    = 7'd5,
    S_DP_IMM     = 7'd6,
    S_DP_ISH     = 7'd7,
    S_DP_RSH     = 7'd8,
    S_BRANCH     = 7'd10,
    S_ADDR_PRE_UP = 7'd33,
    S_LD_START   = 7'd34,
    S_LD_WAIT    = 7'd35,  // load data, waits for moc
    S_LD_DONE    = 7'd36,
    S_ADDR_POST_UP = 7'd37,
    S_WB_POST_UP = 7'd38,
    S_WB_PRE_UP  = 7'd39,
    S_ST_START   = 7'd41,
    S_ST_WAIT    = 7'd42,  // store data, waits for moc
    S_ST_DONE    = 7'd43,
    S_ADDR_PRE_DN = 7'd46,
    S_ADDR_POST_DN = 7'd47,
    S_WB_POST_DN = 7'd48,
    S_WB_PRE_DN  = 7'd49
  } cu_state_e;

  // ir field bit positions
  localparam int IR_P      = 24;
  localparam int IR_U      = 23;
  localparam int IR_W      = 21;
  localparam int IR_L      = 20;
  localparam int IR_OPC_HI = 27;
  localparam int IR_OPC_LO = 25;
  localparam int IR_SH_REG = 4;   // 1: shift amount comes from a register
  localparam int IR_BIT7   = 7;   // set together with bit 4 marks multiply/extra load-store space

  // ir[27:25] classes
  localparam logic [2:0] OPC_DP_REG = 3'b000;
  localparam logic [2:0] OPC_DP_IMM = 3'b001;
  localparam logic [2:0] OPC_LS_IMM = 3'b010;
  localparam logic [2:0] OPC_LS_REG = 3'b011;
  localparam logic [2:0] OPC_BRANCH = 3'b101;

  // Address state for a single load/store: pre/post indexing times up/down.
  function automatic cu_state_e addr_select(input logic p, input logic u);
    cu_state_e s;
    case ({p, u})
      2'b11:   s = S_ADDR_PRE_UP;
      2'b10:   s = S_ADDR_PRE_DN;
      2'b01:   s = S_ADDR_POST_UP;
      default: s = S_ADDR_POST_DN;
    endcase
    return s;
  endfunction

  // Base-register writeback after the memory access. Post-indexed forms always
  // write back; pre-indexed forms only when W is set, otherwise straight to fetch.
  function automatic cu_state_e wb_select(input logic p, input logic w, input logic u);
    cu_state_e s;
    if (!p)
      s = u ? S_WB_POST_UP : S_WB_POST_DN;
    else if (w)
      s = u ? S_WB_PRE_UP : S_WB_PRE_DN;
    else
      s = S_FETCH1;
    return s;
  endfunction

endpackage

// File: rtl/control_state_sequencer_if.sv
// Bus between the control-unit sequencer and the rest of the control unit.
//
// Signals:
//   ir      - instruction register contents
//   cond    - condition-field test result for the current ir
//   moc     - memory operation complete (level)
//   state   - current control state, consumed by the output encoder
//   memErr  - sticky memory-watchdog error flag
//   waitCnt - cycles spent so far in the current moc-wait state
//
// Modports:
//   master - the surrounding datapath / memory side (drives ir, cond, moc)
//   slave  - the sequencer itself
interface control_state_sequencer_if #(
  parameter int TW = 16
) ();

  logic [31:0]   ir;
  logic          cond;
  logic          moc;
  logic [6:0]    state;
  logic          memErr;
  logic [TW-1:0] waitCnt;

  modport master (
    output ir,
    output cond,
    output moc,
    input  state,
    input  memErr,
    input  waitCnt
  );

  modport slave (
    input  ir,
    input  cond,
    input  moc,
    output state,
    output memErr,
    output waitCnt
  );

endinterface

// File: rtl/control_state_sequencer_moc_watchdog.sv
// Memory-wait watchdog. Counts consecutive cycles spent in a moc-wait state
// with moc low and aborts the wait once MOC_TIMEOUT cycles have gone by.
//
// Ports:
//   CLK, RESET - clock and synchronous active-high reset
//   inWait     - sequencer is currently in a moc-wait state
//   moc        - memory operation complete
//   expire     - combinational: this cycle is the last allowed wait cycle and
//                moc is still low, so the sequencer must abort to state 0
//   memErr     - sticky error flag, set on expiry, cleared only by RESET
//   waitCnt    - current wait-cycle count
module moc_watchdog #(
  parameter int MOC_TIMEOUT = 255,
  parameter int TW          = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          inWait,
  input  logic          moc,
  output logic          expire,
  output logic          memErr,
  output logic [TW-1:0] waitCnt
);

  localparam logic [TW-1:0] LIMIT = TW'(MOC_TIMEOUT - 1);

  // moc is excluded from expiry so a completion on the final allowed cycle
  // still wins and the access finishes normally.
  assign expire = inWait && !moc && (waitCnt == LIMIT);

  // Counter runs only while stalled in a wait state; any cycle outside a wait
  // state or with moc high clears it, as does an expiry.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      waitCnt <= '0;
      memErr  <= 1'b0;
    end else if (expire) begin
      waitCnt <= '0;
      memErr  <= 1'b1;
    end else if (inWait && !moc) begin
      waitCnt <= waitCnt + 1'b1;
    end else begin
      waitCnt <= '0;
    end
  end

endmodule

// File: rtl/control_state_sequencer.sv
// Next-state half of the microprogrammed control unit. Holds the 7-bit
// control state and advances it from ir, cond and moc; the output encoder
// turns the state into datapath controls. A watchdog aborts any memory wait
// that stalls for MOC_TIMEOUT cycles and raises a sticky memErr.
//
// Ports:
//   CLK   - system clock, all state changes on the rising edge
//   RESET - synchronous active-high reset, overrides everything
//   bus   - slave side of control_state_sequencer_if
//           (in: ir, cond, moc; out: state, memErr, waitCnt)
module control_state_sequencer
  import control_state_sequencer_pkg::*;
#(
  parameter int MOC_TIMEOUT = 255,
  parameter int TW          = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  control_state_sequencer_if.slave  bus
);

  cu_state_e     state_r;
  logic          in_wait;
  logic          expire;
  logic          mem_err;
  logic [TW-1:0] wait_cnt;
  logic [2:0]    opc;
  logic          p_bit;
  logic          u_bit;
  logic          w_bit;
  logic          l_bit;
  logic          unused_ir_bits;

  assign opc   = bus.ir[IR_OPC_HI:IR_OPC_LO];
  assign p_bit = bus.ir[IR_P];
  assign u_bit = bus.ir[IR_U];
  assign w_bit = bus.ir[IR_W];
  assign l_bit = bus.ir[IR_L];

  // Condition field, register numbers and offsets belong to the datapath.
  assign unused_ir_bits = ^{bus.ir[31:28], bus.ir[22], bus.ir[19:8],
                            bus.ir[6:5], bus.ir[3:0]};

  assign in_wait = (state_r == S_FETCH3) || (state_r == S_LD_WAIT) ||
                   (state_r == S_ST_WAIT);

  moc_watchdog #(
    .MOC_TIMEOUT (MOC_TIMEOUT),
    .TW          (TW)
  ) u_watchdog (
    .CLK     (CLK),
    .RESET   (RESET),
    .inWait  (in_wait),
    .moc     (bus.moc),
    .expire  (expire),
    .memErr  (mem_err),
    .waitCnt (wait_cnt)
  );

  // Wait states advance on moc, abort to state 0 on watchdog expiry and
  // otherwise hold. Unlisted encodings recover through the reset state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= S_RESET;
    end else begin
      case (state_r)
        S_RESET:  state_r <= S_FETCH1;
        S_FETCH1: state_r <= S_FETCH2;
        S_FETCH2: state_r <= S_FETCH3;

        S_FETCH3: begin
          if (bus.moc)
            state_r <= S_DECODE;
          else if (expire)
            state_r <= S_RESET;
        end

        S_DECODE: begin
          if (!bus.cond) begin
            state_r <= S_FETCH1;
          end else begin
            case (opc)
              OPC_DP_IMM: state_r <= S_DP_IMM;
              OPC_DP_REG: begin
                if (!bus.ir[IR_SH_REG])
                  state_r <= S_DP_ISH;
                else if (!bus.ir[IR_BIT7])
                  state_r <= S_DP_RSH;
                else
                  state_r <= S_FETCH1;
              end
              OPC_BRANCH: state_r <= p_bit ? S_BL_LINK : S_BRANCH;
              OPC_LS_IMM,
              OPC_LS_REG: state_r <= addr_select(p_bit, u_bit);
              default:    state_r <= S_FETCH1;
            endcase
          end
        end

        S_DP_IMM, S_DP_ISH, S_DP_RSH, S_BRANCH: state_r <= S_FETCH1;
        S_BL_LINK: state_r <= S_BRANCH;

        S_ADDR_PRE_UP, S_ADDR_PRE_DN, S_ADDR_POST_UP, S_ADDR_POST_DN:
          state_r <= l_bit ? S_LD_START : S_ST_START;

        S_LD_START: state_r <= S_LD_WAIT;
        S_LD_WAIT: begin
          if (bus.moc)
            state_r <= S_LD_DONE;
          else if (expire)
            state_r <= S_RESET;
        end

        S_ST_START: state_r <= S_ST_WAIT;
        S_ST_WAIT: begin
          if (bus.moc)
            state_r <= S_ST_DONE;
          else if (expire)
            state_r <= S_RESET;
        end

        S_LD_DONE, S_ST_DONE: state_r <= wb_select(p_bit, w_bit, u_bit);

        S_WB_POST_UP, S_WB_POST_DN, S_WB_PRE_UP, S_WB_PRE_DN:
          state_r <= S_FETCH1;

        default: state_r <= S_RESET;
      endcase
    end
  end

  assign bus.state   = state_r;
  assign bus.memErr  = mem_err;
  assign bus.waitCnt = wait_cnt;

endmodule

// File: tb/tb_control_state_sequencer.sv
// Self-checking bench for control_state_sequencer. A table of instructions
// with hand-derived state sequences covers decode, execute, load/store and
// writeback paths; hand-written sequences cover reset during a wait, watchdog
// expiry in fetch and store waits, moc winning on the expiry cycle, and
// recovery from illegal state encodings.
module tb_control_state_sequencer;
  import control_state_sequencer_pkg::*;

  localparam int TW      = 16;
  localparam int TIMEOUT = 8;

  logic CLK = 1'b0;
  logic RESET;

  control_state_sequencer_if #(.TW(TW)) bus ();

  control_state_sequencer #(
    .MOC_TIMEOUT (TIMEOUT),
    .TW          (TW)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int fails  = 0;

  // seq lists the states expected after leaving fetch state 3, ending at 1;
  // trailing entries are padding.
  typedef struct packed {
    logic [31:0]      ir;
    logic             cond;
    logic [0:9][6:0]  seq;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic [31:0] ir, input logic cond,
                              input logic [0:9][6:0] seq);
    vec_t v;
    v.ir   = ir;
    v.cond = cond;
    v.seq  = seq;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Inputs change on the falling edge, one rising edge is taken, and outputs
  // are then observed on the following falling edge.
  task automatic applyStimulus(input logic rst, input logic [31:0] ir_v,
                               input logic cond_v, input logic moc_v);
    RESET    = rst;
    bus.ir   = ir_v;
    bus.cond = cond_v;
    bus.moc  = moc_v;
    tick();
  endtask

  task automatic checkOutput(input string what, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", what, actual, expected);
    end
  endtask

  task automatic run_vector(input int k);
    logic [6:0] prev;
    logic [6:0] e;
    vec_t v;
    v = vecs[k];
    applyStimulus(1'b1, v.ir, v.cond, 1'b1);
    checkOutput($sformatf("vec%0d reset", k), bus.state, 0);
    prev = 7'd0;
    for (int i = 0; i < 13; i++) begin
      e = (i < 3) ? 7'(i + 1) : v.seq[i-3];
      // A repeated expected state is a memory stall: hold moc low for it.
      applyStimulus(1'b0, v.ir, v.cond, (e == prev) ? 1'b0 : 1'b1);
      checkOutput($sformatf("vec%0d step%0d state", k, i), bus.state, e);
      prev = e;
      if (i >= 3 && e == 7'd1) break;
    end
    checkOutput($sformatf("vec%0d memErr", k), bus.memErr, 0);
  endtask

  task automatic force_illegal(input logic [6:0] s);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    force dut.state_r = cu_state_e'(s);
    #1;
    release dut.state_r;
    tick();
    checkOutput($sformatf("illegal %0d -> 0", s), bus.state, 0);
  endtask

  localparam logic [31:0] LDR_PRE = 32'hE5912004;
  localparam logic [31:0] STR_PRE = 32'hE5812000;
  localparam logic [31:0] ADD_IMM = 32'hE2811005;

  initial begin
    RESET    = 1'b1;
    bus.ir   = '0;
    bus.cond = 1'b0;
    bus.moc  = 1'b0;

    vecs[0]  = mk(32'hE2811005, 1'b1, {7'd4, 7'd6, 7'd1, {7{7'd0}}});
    vecs[1]  = mk(32'hE2811005, 1'b0, {7'd4, 7'd1, {8{7'd0}}});
    vecs[2]  = mk(32'hEB000002, 1'b1, {7'd4, 7'd5, 7'd10, 7'd1, {6{7'd0}}});
    vecs[3]  = mk(32'hEA000002, 1'b1, {7'd4, 7'd10, 7'd1, {7{7'd0}}});
    vecs[4]  = mk(32'hE5912004, 1'b1, {7'd4, 7'd33, 7'd34, 7'd35, 7'd35, 7'd35,
                                       7'd35, 7'd36, 7'd1, {1{7'd0}}});
    vecs[5]  = mk(32'hE4912004, 1'b1, {7'd4, 7'd37, 7'd34, 7'd35, 7'd36, 7'd38,
                                       7'd1, {3{7'd0}}});
    vecs[6]  = mk(32'hE5B12004, 1'b1, {7'd4, 7'd33, 7'd34, 7'd35, 7'd36, 7'd39,
                                       7'd1, {3{7'd0}}});
    vecs[7]  = mk(32'hE5812000, 1'b1, {7'd4, 7'd33, 7'd41, 7'd42, 7'd43, 7'd1,
                                       {4{7'd0}}});
    vecs[8]  = mk(32'hE5012000, 1'b1, {7'd4, 7'd46, 7'd41, 7'd42, 7'd43, 7'd1,
                                       {4{7'd0}}});
    vecs[9]  = mk(32'hE5A12004, 1'b1, {7'd4, 7'd33, 7'd41, 7'd42, 7'd42, 7'd43,
                                       7'd39, 7'd1, {2{7'd0}}});
    vecs[10] = mk(32'hE4112004, 1'b1, {7'd4, 7'd47, 7'd34, 7'd35, 7'd36, 7'd48,
                                       7'd1, {3{7'd0}}});
    vecs[11] = mk(32'hE5312004, 1'b1, {7'd4, 7'd46, 7'd34, 7'd35, 7'd36, 7'd49,
                                       7'd1, {3{7'd0}}});
    vecs[12] = mk(32'hE0811002, 1'b1, {7'd4, 7'd7, 7'd1, {7{7'd0}}});
    vecs[13] = mk(32'hE0811312, 1'b1, {7'd4, 7'd8, 7'd1, {7{7'd0}}});
    vecs[14] = mk(32'hE0010091, 1'b1, {7'd4, 7'd1, {8{7'd0}}});
    vecs[15] = mk(32'hE8BD0001, 1'b1, {7'd4, 7'd1, {8{7'd0}}});

    tick();
    $display("[TB] table-driven decode/execute vectors");
    for (int k = 0; k < 16; k++) run_vector(k);

    $display("[TB] reset while waiting in state 35");
    applyStimulus(1'b1, LDR_PRE, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, LDR_PRE, 1'b1, 1'b1);
    checkOutput("ldr reached 35", bus.state, 35);
    checkOutput("waitCnt on entry", bus.waitCnt, 0);
    applyStimulus(1'b0, LDR_PRE, 1'b1, 1'b0);
    checkOutput("waitCnt after 1 stall", bus.waitCnt, 1);
    applyStimulus(1'b0, LDR_PRE, 1'b1, 1'b0);
    checkOutput("waitCnt after 2 stalls", bus.waitCnt, 2);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, LDR_PRE, 1'b1, 1'b0);
      checkOutput($sformatf("reset%0d state", i), bus.state, 0);
      checkOutput($sformatf("reset%0d memErr", i), bus.memErr, 0);
      checkOutput($sformatf("reset%0d waitCnt", i), bus.waitCnt, 0);
    end
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, ADD_IMM, 1'b1, 1'b0);
      checkOutput($sformatf("post-reset fetch %0d", i), bus.state, i);
    end

    $display("[TB] watchdog expiry in fetch wait");
    for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(1'b0, ADD_IMM, 1'b1, 1'b0);
    checkOutput("fetch stall still in 3", bus.state, 3);
    checkOutput("fetch stall waitCnt", bus.waitCnt, TIMEOUT - 1);
    checkOutput("memErr before expiry", bus.memErr, 0);
    applyStimulus(1'b0, ADD_IMM, 1'b1, 1'b0);
    checkOutput("expiry state", bus.state, 0);
    checkOutput("expiry memErr", bus.memErr, 1);
    checkOutput("expiry waitCnt", bus.waitCnt, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b0, ADD_IMM, 1'b1, 1'b1);
    checkOutput("refetch reaches decode", bus.state, 4);
    checkOutput("memErr sticky", bus.memErr, 1);
    applyStimulus(1'b0, ADD_IMM, 1'b1, 1'b1);
    checkOutput("refetch executes", bus.state, 6);
    checkOutput("memErr still sticky", bus.memErr, 1);
    applyStimulus(1'b1, ADD_IMM, 1'b1, 1'b1);
    checkOutput("reset clears memErr", bus.memErr, 0);

    $display("[TB] moc on the expiry cycle");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, ADD_IMM, 1'b1, 1'b0);
    checkOutput("in fetch wait", bus.state, 3);
    for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(1'b0, ADD_IMM, 1'b1, 1'b0);
    applyStimulus(1'b0, ADD_IMM, 1'b1, 1'b1);
    checkOutput("moc wins state", bus.state, 4);
    checkOutput("moc wins memErr", bus.memErr, 0);

    $display("[TB] watchdog expiry in store wait");
    applyStimulus(1'b1, STR_PRE, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, STR_PRE, 1'b1, 1'b1);
    checkOutput("str reached 42", bus.state, 42);
    for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(1'b0, STR_PRE, 1'b1, 1'b0);
    checkOutput("store stall still in 42", bus.state, 42);
    applyStimulus(1'b0, STR_PRE, 1'b1, 1'b0);
    checkOutput("store expiry state", bus.state, 0);
    checkOutput("store expiry memErr", bus.memErr, 1);

    $display("[TB] illegal state recovery");
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b1);
    force_illegal(7'd9);
    force_illegal(7'd100);
    force_illegal(7'd40);
    force_illegal(7'd11);
    force_illegal(7'd127);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
